// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// byte-order constants for the header, data and checksum fields, and the
// default geometry of the instruction memory.
package loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CSUM_HI,
    CSUM_LO,
    DONE
  } state_e;

  localparam int unsigned DEFAULT_ADDR_W     = 16;
  localparam int unsigned DEFAULT_START_ADDR = 0;

  // The first byte received for every 16-bit field is its high byte
  localparam bit HDR_BIG_ENDIAN  = 1'b1;
  localparam bit DATA_BIG_ENDIAN = 1'b1;
  localparam bit CSUM_BIG_ENDIAN = 1'b1;

  // Join two stream bytes into a 16-bit field in the given byte order
  function automatic logic [15:0] join_bytes(input logic [7:0] first,
                                             input logic [7:0] second,
                                             input bit         big_endian);
    return big_endian ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running 16-bit sum of the words written during a load, with a compare
// against the checksum field received at the end of the stream. Only built
// when LOADER_CHECKSUM_EN is defined.
module loader_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add,
  input  logic [15:0] add_word,
  input  logic [15:0] cmp_word,
  output logic        match
);

  logic [15:0] sum_q;
  logic [15:0] sum_d;

  // Next sum: clear wins over add, the sum wraps modulo 2^16
  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_q + add_word;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match = (sum_q == cmp_word);

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: parses a 16-bit big-endian word count, then
// assembles byte pairs into 16-bit words and writes them to consecutive
// addresses starting at START_ADDR, holding the CPU until the load finishes.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing 16-bit checksum
// field that must equal the modulo-2^16 sum of all data words.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEFAULT_START_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  // Largest word count that fits between START_ADDR and the top of memory
  localparam logic [32:0] ADDR_SPAN  = 33'd1 << ADDR_W;
  localparam logic [32:0] LOAD_LIMIT = ADDR_SPAN - 33'(START_ADDR);

  state_e            state_q,     state_d;
  logic [7:0]        hdr_hi_q,    hdr_hi_d;
  logic [7:0]        byte_hi_q,   byte_hi_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [15:0]       wdata_q,     wdata_d;
  logic              we_q,        we_d;
  logic              in_ready_q,  in_ready_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  logic              cpu_hold_q,  cpu_hold_d;

  logic              accept;
  logic [15:0]       hdr_count;
  logic              overflow;

  assign accept    = in_valid && in_ready_q;
  assign hdr_count = join_bytes(hdr_hi_q, in_data, HDR_BIG_ENDIAN);
  assign overflow  = 33'(hdr_count) > LOAD_LIMIT;

`ifdef LOADER_CHECKSUM_EN
  logic        csum_clear;
  logic        csum_add;
  logic        csum_match;
  logic [15:0] csum_word;

  assign csum_word = join_bytes(byte_hi_q, in_data, CSUM_BIG_ENDIAN);

  loader_checksum u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clear    (csum_clear),
    .add      (csum_add),
    .add_word (wdata_q),
    .cmp_word (csum_word),
    .match    (csum_match)
  );
`endif

  // Next-state, byte assembly, address counter and registered-output values
  always_comb begin
    state_d     = state_q;
    hdr_hi_d    = hdr_hi_q;
    byte_hi_d   = byte_hi_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_clear  = 1'b0;
    csum_add    = 1'b0;
`endif

    case (state_q)
      IDLE, DONE: begin
        // start is ignored while a load is in progress
        if (start) begin
          state_d = LEN_HI;
          err_d   = 1'b0;
          addr_d  = START_ADDR;
`ifdef LOADER_CHECKSUM_EN
          csum_clear = 1'b1;
`endif
        end
      end
      LEN_HI: begin
        if (accept) begin
          hdr_hi_d = in_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          remaining_d = hdr_count;
          if (overflow) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (hdr_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM_HI;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          byte_hi_d = in_data;
          state_d   = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          wdata_d = join_bytes(byte_hi_q, in_data, DATA_BIG_ENDIAN);
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Address stays put during the strobe and advances afterwards
        addr_d      = addr_q + ADDR_W'(1);
        remaining_d = remaining_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_add = 1'b1;
`endif
        if (remaining_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CSUM_HI;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM_HI: begin
        if (accept) begin
          byte_hi_d = in_data;
          state_d   = CSUM_LO;
        end
      end
      CSUM_LO: begin
        if (accept) begin
          if (!csum_match) begin
            err_d = 1'b1;
          end
          state_d = DONE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered
    // alongside it, with no combinational path from in_valid
    we_d       = (state_d == WRITE);
    in_ready_d = (state_d == LEN_HI)  || (state_d == LEN_LO)  ||
                 (state_d == DATA_HI) || (state_d == DATA_LO) ||
                 (state_d == CSUM_HI) || (state_d == CSUM_LO);
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);
    cpu_hold_d = (state_d != DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hdr_hi_q    <= '0;
      byte_hi_q   <= '0;
      remaining_q <= '0;
      addr_q      <= START_ADDR;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_hold_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      hdr_hi_q    <= hdr_hi_d;
      byte_hi_q   <= byte_hi_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_hold  = cpu_hold_q;

endmodule
